// File: rtl/shift_pkg.sv
// Shared op codes, FSM state encoding and default widths for the multicycle shifter.
package shift_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned OP_W    = 3;

    localparam logic [OP_W-1:0] OP_SLL = 3'b000;
    localparam logic [OP_W-1:0] OP_SRL = 3'b001;
    localparam logic [OP_W-1:0] OP_SRA = 3'b010;
    localparam logic [OP_W-1:0] OP_ROR = 3'b011;
    localparam logic [OP_W-1:0] OP_ROL = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Codes above ROL are reserved and treated as pass-through.
    function automatic logic op_valid(input logic [OP_W-1:0] op);
        return op <= OP_ROL;
    endfunction

endpackage

// File: rtl/shift_unit_if.sv
// Request/response bundle between the control unit and the shifter.
interface shift_unit_if;
    import shift_pkg::*;

    logic               SHIFT_START;
    logic [OP_W-1:0]    SHIFT_OP;
    logic [SHAMT_W-1:0] SHIFT_AMT;
    logic [DATA_W-1:0]  SHIFT_IN;
    logic               SHIFT_BUSY;
    logic               SHIFT_DONE;
    logic [DATA_W-1:0]  shift_reg_output;

    modport master (
        output SHIFT_START, SHIFT_OP, SHIFT_AMT, SHIFT_IN,
        input  SHIFT_BUSY, SHIFT_DONE, shift_reg_output
    );

    modport slave (
        input  SHIFT_START, SHIFT_OP, SHIFT_AMT, SHIFT_IN,
        output SHIFT_BUSY, SHIFT_DONE, shift_reg_output
    );

endinterface

// File: rtl/shift_step.sv
// Single-bit shift/rotate of a value; reserved op codes leave the value unchanged.
module shift_step
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0] value,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] stepped_c
);

    always_comb begin
        stepped_c = value;
        case (op)
            OP_SLL:  stepped_c = {value[DATA_W-2:0], 1'b0};
            OP_SRL:  stepped_c = {1'b0, value[DATA_W-1:1]};
            OP_SRA:  stepped_c = {value[DATA_W-1], value[DATA_W-1:1]};
            OP_ROR:  stepped_c = {value[0], value[DATA_W-1:1]};
            OP_ROL:  stepped_c = {value[DATA_W-2:0], value[DATA_W-1]};
            default: stepped_c = value;
        endcase
    end

endmodule

// File: rtl/shift_unit.sv
// Multicycle shifter: one bit per clock under a counter-driven FSM, result held
// after a one-cycle done pulse for selection into the write-back mux.
module shift_unit
    import shift_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    shift_unit_if.slave  bus
);

    state_e             state, state_next;
    logic [SHAMT_W-1:0] cnt, cnt_next;
    logic [OP_W-1:0]    op_q, op_next;
    logic [DATA_W-1:0]  result, result_next;
    logic [DATA_W-1:0]  stepped_c;
    logic               busy, done;

    shift_step u_step (
        .value     (result),
        .op        (op_q),
        .stepped_c (stepped_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            op_q   <= OP_SLL;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            op_q   <= op_next;
            result <= result_next;
            busy   <= (state_next != ST_IDLE);
            done   <= (state_next == ST_DONE);
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        op_next     = op_q;
        result_next = result;
        case (state)
            ST_IDLE: begin
                if (bus.SHIFT_START) begin
                    result_next = bus.SHIFT_IN;
                    cnt_next    = bus.SHIFT_AMT;
                    op_next     = bus.SHIFT_OP;
                    // Zero count and reserved codes skip straight to DONE as pass-through.
                    if ((bus.SHIFT_AMT != '0) && op_valid(bus.SHIFT_OP)) begin
                        state_next = ST_SHIFT;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                result_next = stepped_c;
                cnt_next    = cnt - SHAMT_W'(1);
                if (cnt == SHAMT_W'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.SHIFT_BUSY       = busy;
    assign bus.SHIFT_DONE       = done;
    assign bus.shift_reg_output = result;

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit: directed cases plus random ops against an arithmetic reference.
module tb_shift_unit;
    import shift_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    shift_unit_if bus ();

    shift_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference result from plain shift arithmetic on the whole word.
    function automatic logic [31:0] ref_shift(input logic [2:0] op, input int n, input logic [31:0] x);
        if (op > 3'd4 || n == 0) return x;
        case (op)
            3'd0:    return x << n;
            3'd1:    return x >> n;
            3'd2:    return 32'($signed(x) >>> n);
            3'd3:    return (x >> n) | (x << (32 - n));
            default: return (x << n) | (x >> (32 - n));
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op; optionally pulse an SRL start mid-shift and during DONE (both must be ignored).
    task automatic run_op(input logic [2:0] op, input logic [4:0] amt, input logic [31:0] din,
                          input bit inject, input string tag);
        int          n_eff;
        int          lat;
        int          busy_cnt;
        logic [31:0] exp;
        n_eff    = (op > 3'd4) ? 0 : int'(amt);
        exp      = ref_shift(op, int'(amt), din);
        lat      = 0;
        busy_cnt = 0;
        @(negedge clk);
        bus.SHIFT_START = 1'b1;
        bus.SHIFT_OP    = op;
        bus.SHIFT_AMT   = amt;
        bus.SHIFT_IN    = din;
        @(posedge clk); #1;
        bus.SHIFT_START = 1'b0;
        bus.SHIFT_IN    = $urandom;
        bus.SHIFT_OP    = 3'($urandom);
        bus.SHIFT_AMT   = 5'($urandom);
        while (!bus.SHIFT_DONE && lat < 40) begin
            if (bus.SHIFT_BUSY) busy_cnt++;
            bus.SHIFT_START = inject && (lat == 2);
            if (inject && lat == 2) bus.SHIFT_OP = OP_SRL;
            @(posedge clk); #1;
            lat++;
        end
        bus.SHIFT_START = 1'b0;
        if (bus.SHIFT_BUSY) busy_cnt++;
        check({tag, " latency"}, 32'(lat), 32'(n_eff));
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(n_eff + 1));
        check({tag, " result"}, bus.shift_reg_output, exp);
        if (inject) bus.SHIFT_START = 1'b1;
        @(posedge clk); #1;
        bus.SHIFT_START = 1'b0;
        check({tag, " busy_after"}, 32'(bus.SHIFT_BUSY), 32'd0);
        check({tag, " done_after"}, 32'(bus.SHIFT_DONE), 32'd0);
        check({tag, " result_hold"}, bus.shift_reg_output, exp);
    endtask

    initial begin
        bit done_seen;
        reset           = 1'b1;
        bus.SHIFT_START = 1'b0;
        bus.SHIFT_OP    = '0;
        bus.SHIFT_AMT   = '0;
        bus.SHIFT_IN    = '0;
        #2;
        check("reset result", bus.shift_reg_output, 32'd0);
        check("reset busy", 32'(bus.SHIFT_BUSY), 32'd0);
        check("reset done", 32'(bus.SHIFT_DONE), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_op(OP_SLL, 5'd4,  32'h0000_0001, 1'b0, "sll4");
        run_op(OP_SRA, 5'd31, 32'h8000_0000, 1'b0, "sra31");
        run_op(OP_SRL, 5'd31, 32'h8000_0000, 1'b0, "srl31");
        run_op(OP_ROR, 5'd1,  32'h0000_0001, 1'b0, "ror1");
        run_op(OP_ROL, 5'd4,  32'h8000_0001, 1'b0, "rol4");
        run_op(OP_SLL, 5'd0,  32'hDEAD_BEEF, 1'b0, "sll0");
        run_op(3'b111, 5'd9,  32'hDEAD_BEEF, 1'b0, "rsvd9");
        run_op(OP_SLL, 5'd8,  32'h0000_00FF, 1'b1, "ignore_start");

        // Abort mid-operation with reset.
        @(negedge clk);
        bus.SHIFT_START = 1'b1;
        bus.SHIFT_OP    = OP_SLL;
        bus.SHIFT_AMT   = 5'd10;
        bus.SHIFT_IN    = 32'h1234_5678;
        @(posedge clk); #1;
        bus.SHIFT_START = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort result", bus.shift_reg_output, 32'd0);
        check("abort busy", 32'(bus.SHIFT_BUSY), 32'd0);
        check("abort done", 32'(bus.SHIFT_DONE), 32'd0);
        done_seen = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (bus.SHIFT_DONE) done_seen = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.SHIFT_DONE || bus.SHIFT_BUSY) done_seen = 1'b1;
        end
        check("abort no_done", 32'(done_seen), 32'd0);
        run_op(OP_ROL, 5'd7, 32'hF000_000F, 1'b0, "post_reset");

        for (int i = 0; i < 25; i++) begin
            run_op(3'($urandom_range(0, 7)), 5'($urandom), $urandom, 1'b0, "rand");
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
